// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arbiter: ALU opcodes, datapath widths and
// the IDLE/ISSUE/RESP state encoding.
package calc_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_MOD = 3'b100;
  localparam logic [OP_W-1:0] OP_AND = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [OP_W-1:0] OP_OR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  function automatic logic is_div_zero(input logic [OP_W-1:0] op,
                                       input logic [DATA_W-1:0] b);
    return (op == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester at/after ptr wins, else the
// lowest requester overall (wrap-around).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [NUM_REQ-1:0] hi_req;
  logic [ID_W-1:0]    idx_hi;
  logic [ID_W-1:0]    idx_lo;

  always_comb begin
    hi_req = '0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = req[i] && (i >= int'(ptr));
    end
    // Scan downward so the lowest set index is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i])    idx_lo = ID_W'(i);
      if (hi_req[i]) idx_hi = ID_W'(i);
    end
    grant_any = |req;
    grant_idx = (|hi_req) ? idx_hi : idx_lo;
    grant     = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// registered operands, fixed settle time, captured and tagged response.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [RES_W-1:0]          alu_out,
  input  logic                      alu_carry,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_carry,
  output logic                      rsp_zero,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [15:0]               op_count
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;
  logic [15:0]         op_count_q, op_count_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [OP_W-1:0]     sel_op;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts as its _q, so no branch below can leave a latch behind.
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          alu_op_d = sel_op;
          rsp_id_d = grant_idx;
          ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
          err_d    = is_div_zero(sel_op, sel_b);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          // A blocked divide keeps the normal latency but reports zeros.
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_data_d  = err_q ? '0 : alu_out;
          rsp_carry_d = err_q ? 1'b0 : alu_carry;
          rsp_zero_d  = err_q ? 1'b0 : alu_zero;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here, so every flop samples pre-edge _d values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready = (rst_n && state_q == S_IDLE) ? grant : '0;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: a transaction-level model checked every cycle plus
// directed scenarios with literal expectations; a second instance covers SETTLE_CYCLES=3.
module tb_calc_arbiter;
  import calc_pkg::*;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int SETTLE  = 1;
  localparam int SETTLE3 = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_ready3, sticky;
  logic [N*8-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [7:0]     alu_a, alu_b, alu_a3, alu_b3;
  logic [2:0]     alu_op, alu_op3;
  logic [15:0]    alu_out, alu_out3;
  logic           alu_carry, alu_zero, alu_carry3, alu_zero3;
  logic           rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err, busy;
  logic [IDW-1:0] rsp_id, rsp_id3;
  logic [15:0]    rsp_data, op_count, rsp_data3, op_count3;
  logic           rsp_valid3, rsp_ready3, rsp_carry3, rsp_zero3, rsp_err3, busy3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared calculator: {carry, zero, out}.
  function automatic logic [17:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    r = '0;
    case (op)
      OP_ADD: begin r = 16'(a) + 16'(b); c = r[8]; end
      OP_SUB: begin r = 16'(a) - 16'(b); c = (a < b); end
      OP_MUL: r = 16'(a) * 16'(b);
      OP_DIV: if (b == 0) begin r = 16'hFFFF; c = 1'b1; end else r = 16'(a / b);
      OP_MOD: if (b == 0) begin r = 16'hFFFF; c = 1'b1; end else r = 16'(a % b);
      OP_AND: r = {8'h00, a & b};
      OP_XOR: r = {8'h00, a ^ b};
      default: r = {8'h00, a | b};
    endcase
    return {c, (r == 16'd0), r};
  endfunction

  assign {alu_carry, alu_zero, alu_out}    = alu_ref(alu_a, alu_b, alu_op);
  assign {alu_carry3, alu_zero3, alu_out3} = alu_ref(alu_a3, alu_b3, alu_op3);
  assign rsp_ready3 = 1'b1;

  calc_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE), .ID_W(IDW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  calc_arbiter #(.NUM_REQ(N), .SETTLE_CYCLES(SETTLE3), .ID_W(IDW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_out(alu_out3), .alu_carry(alu_carry3), .alu_zero(alu_zero3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .rsp_carry(rsp_carry3), .rsp_zero(rsp_zero3), .rsp_err(rsp_err3),
    .busy(busy3), .op_count(op_count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int from);
    int i;
    for (int j = 0; j < N; j++) begin
      i = (from + j) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Transaction model: a grant opens an operation whose result appears SETTLE
  // edges later and stays up until accepted.
  int             cyc = 0;
  int             cap_at = 0;
  int             m_ptr = 0;
  int             m_w;
  bit             m_issue = 1'b0;
  bit             m_rsp = 1'b0;
  logic [IDW-1:0] e_id = '0;
  logic [7:0]     e_a = '0, e_b = '0;
  logic [2:0]     e_op = '0;
  logic [15:0]    e_data = '0, e_cnt = '0;
  logic           e_carry = 1'b0, e_zero = 1'b0, e_err = 1'b0, pend_err = 1'b0;
  logic [17:0]    pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; cap_at = 0; m_ptr = 0; m_issue = 1'b0; m_rsp = 1'b0;
      e_id = '0; e_a = '0; e_b = '0; e_op = '0; e_data = '0; e_cnt = '0;
      e_carry = 1'b0; e_zero = 1'b0; e_err = 1'b0;
    end else begin
      cyc++;
      if (m_rsp) begin
        if (rsp_ready) begin
          m_rsp = 1'b0;
          e_cnt = e_cnt + 16'd1;
        end
      end else if (m_issue) begin
        if (cyc == cap_at) begin
          m_issue = 1'b0;
          m_rsp   = 1'b1;
          e_err   = pend_err;
          {e_carry, e_zero, e_data} = pend;
        end
      end else begin
        m_w = rr_pick(req_valid, m_ptr);
        if (m_w >= 0) begin
          m_issue  = 1'b1;
          cap_at   = cyc + SETTLE;
          e_id     = IDW'(m_w);
          e_a      = req_a[m_w*8 +: 8];
          e_b      = req_b[m_w*8 +: 8];
          e_op     = req_op[m_w*3 +: 3];
          m_ptr    = (m_w + 1) % N;
          pend_err = (e_op == OP_DIV) && (e_b == 8'd0);
          pend     = pend_err ? 18'd0 : alu_ref(e_a, e_b, e_op);
        end
      end
    end
  end

  logic [N-1:0] cmp_er;
  int           cmp_w;

  always @(negedge clk) begin
    cmp_er = '0;
    if (rst_n && !m_issue && !m_rsp) begin
      cmp_w = rr_pick(req_valid, m_ptr);
      if (cmp_w >= 0) cmp_er[cmp_w] = 1'b1;
    end
    check("m_req_ready", req_ready, cmp_er);
    check("m_busy", busy, m_issue || m_rsp);
    check("m_rsp_valid", rsp_valid, m_rsp);
    check("m_rsp_id", rsp_id, e_id);
    check("m_rsp_data", rsp_data, e_data);
    check("m_rsp_carry", rsp_carry, e_carry);
    check("m_rsp_zero", rsp_zero, e_zero);
    check("m_rsp_err", rsp_err, e_err);
    check("m_alu_a", alu_a, e_a);
    check("m_alu_b", alu_b, e_b);
    check("m_alu_op", alu_op, e_op);
    check("m_op_count", op_count, e_cnt);
  end

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*3 +: 3] = op;
    req_valid[i]     = 1'b1;
  endtask

  // One clock: requesters that handshook drop valid unless marked sticky.
  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(hs & ~sticky);
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      edges++;
      if (rsp_valid) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL rsp_timeout @%0t: no rsp_valid within 20 cycles", $time);
  endtask

  task automatic drain();
    req_valid = '0;
    sticky    = '0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 20 && (busy || rsp_valid); t++) cycle();
  endtask

  task automatic do_reset();
    req_valid = '0;
    sticky    = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    cycle();
    rst_n     = 1'b1;
  endtask

  initial begin
    int edges, lat1, lat3;
    logic [15:0] data3;
    rst_n = 1'b0; req_valid = '0; sticky = '0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b1;
    #3;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single add from requester 0.
    set_req(0, 8'd1, 8'd1, OP_ADD);
    #1;
    check("t1_ready", req_ready, 4'b0001);
    wait_rsp(edges);
    check("t1_latency", edges - 1, SETTLE);
    check("t1_data", rsp_data, 16'd2);
    check("t1_id", rsp_id, 0);
    check("t1_err", rsp_err, 0);
    drain();

    // All four at once from pointer 0: served in index order.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(i), 8'd3, OP_ADD);
    for (int k = 0; k < N; k++) begin
      wait_rsp(edges);
      check("t2_id", rsp_id, k);
      check("t2_data", rsp_data, k + 3);
    end
    drain();

    // Requesters 1 and 2 hold valid continuously: grants alternate.
    do_reset();
    sticky = 4'b0110;
    set_req(1, 8'd10, 8'd20, OP_SUB);
    set_req(2, 8'd7, 8'd7, OP_XOR);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(edges);
      check("t3_id", rsp_id, (k % 2 == 0) ? 1 : 2);
      if (k == 0) check("t3_sub_data", rsp_data, 16'hFFF6);
    end
    drain();

    // Divide by zero is blocked with unchanged latency; a legal divide follows.
    set_req(0, 8'd9, 8'd0, OP_DIV);
    wait_rsp(edges);
    check("t4_latency", edges - 1, SETTLE);
    check("t4_err", rsp_err, 1);
    check("t4_data", rsp_data, 0);
    check("t4_carry", rsp_carry, 0);
    check("t4_zero", rsp_zero, 0);
    drain();
    set_req(0, 8'd9, 8'd3, OP_DIV);
    wait_rsp(edges);
    check("t4b_err", rsp_err, 0);
    check("t4b_data", rsp_data, 16'd3);
    drain();

    // Consumer stalls for five cycles while another requester waits.
    do_reset();
    rsp_ready = 1'b0;
    set_req(2, 8'd200, 8'd100, OP_ADD);
    wait_rsp(edges);
    check("t5_data", rsp_data, 16'd300);
    check("t5_carry", rsp_carry, 1);
    set_req(3, 8'd1, 8'd2, OP_OR);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t5_hold_valid", rsp_valid, 1);
      check("t5_hold_data", rsp_data, 16'd300);
      check("t5_hold_id", rsp_id, 2);
      check("t5_hold_ready", req_ready, 0);
      check("t5_hold_count", op_count, 0);
    end
    rsp_ready = 1'b1;
    cycle();
    check("t5_accept_valid", rsp_valid, 0);
    check("t5_accept_count", op_count, 1);
    wait_rsp(edges);
    check("t5_next_id", rsp_id, 3);
    check("t5_next_data", rsp_data, 16'd3);
    drain();
    check("t5_final_count", op_count, 2);

    // Reset in the middle of an operation discards it on both instances.
    do_reset();
    set_req(0, 8'd5, 8'd6, OP_MUL);
    cycle();
    check("t6_busy_pre", busy, 1);
    check("t6_busy3_pre", busy3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_busy3", busy3, 0);
    check("t6_alu_a", alu_a, 0);
    check("t6_alu_a3", alu_a3, 0);
    check("t6_alu_op", alu_op, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t6_no_rsp", rsp_valid, 0);
      check("t6_no_rsp3", rsp_valid3, 0);
    end

    // Same request into both builds: capture one edge after grant vs three.
    set_req(1, 8'd7, 8'd8, OP_ADD);
    lat1 = -1;
    lat3 = -1;
    data3 = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (rsp_valid && lat1 < 0) lat1 = i;
      if (rsp_valid3 && lat3 < 0) begin
        lat3  = i;
        data3 = rsp_data3;
      end
    end
    check("t6_lat1", lat1, SETTLE);
    check("t6_lat3", lat3, SETTLE3);
    check("t6_data3", data3, 16'd15);
    check("t6_count3", op_count3, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
